// File: rtl/vga_gfx_pkg.sv
// Shared types and peripheral register-bus encodings for the VGA graphics line refill DMA.
package vga_gfx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        GAP,
        DONE
    } state_t;

    localparam logic [5:0] GFX_REG_IRQ = 6'h01;
    localparam logic [1:0] GFX_WR32    = 2'b10;
    localparam logic [1:0] GFX_RD8     = 2'b00;
    localparam logic [1:0] GFX_IDLE    = 2'b11;

endpackage

// File: rtl/vga_gfx_line_addr_gen.sv
// Line counter and multiplier-free line base address: the stride is accumulated once per
// completed refill instead of multiplying line * stride.
module vga_gfx_line_addr_gen
    import vga_gfx_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int LINE_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [LINE_W-1:0] num_lines,
    input  logic              clear,
    input  logic              advance,
    output logic [LINE_W-1:0] line,
    output logic [ADDR_W-1:0] line_base
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] acc;
    logic [LINE_W-1:0] last_line;
    logic              wrap;

    // A line count of zero behaves as a single-line frame.
    assign last_line = (num_lines == '0) ? '0 : num_lines - LINE_W'(1);
    assign wrap      = (line >= last_line);
    assign line_base = (base_addr & WORD_MASK) + acc;

    // NOTE: every register here, the line counter included, is cleared by the asynchronous
    // reset so the first refill after reset always starts at line 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
            acc  <= '0;
        end else if (clear) begin
            line <= '0;
            acc  <= '0;
        end else if (advance) begin
            if (wrap) begin
                line <= '0;
                acc  <= '0;
            end else begin
                line <= line + LINE_W'(1);
                acc  <= acc + (stride & WORD_MASK);
            end
        end
    end

endmodule

// File: rtl/vga_gfx_line_dma.sv
// Refills the graphics peripheral's 16-word pixel latch bank from memory on each raster
// interrupt: ack-read of the IRQ register, then paced fetch/write pairs.
module vga_gfx_line_dma
    import vga_gfx_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int WORDS  = 16,
    parameter int WR_GAP = 8,
    parameter int LINE_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [LINE_W-1:0] num_lines,
    input  logic              frame_start,
    input  logic              gfx_irq,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [5:0]        gfx_address,
    output logic [31:0]       gfx_data,
    output logic [1:0]        gfx_write_n,
    output logic [1:0]        gfx_read_n,
    output logic              busy,
    output logic [LINE_W-1:0] line,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int                GAP_W     = (WR_GAP > 2) ? $clog2(WR_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(WR_GAP - 2);
    localparam logic [3:0]        LAST_WORD = 4'(WORDS - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state;
    logic [3:0]        word;
    logic [3:0]        word_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic              irq_q;
    logic              enable_q;
    logic              fs_pending;
    logic              trigger;
    logic              restart;
    logic              idle_clear;
    logic              done_go;
    logic              gen_clear;
    logic              gen_advance;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] start_base;

    assign trigger   = gfx_irq & ~irq_q;
    assign restart   = frame_start | fs_pending;
    assign word_next = word + 4'd1;
    assign busy      = (state != IDLE);

    assign idle_clear  = (state == IDLE) & restart;
    assign done_go     = (state == DONE) & enable;
    assign gen_clear   = idle_clear | (done_go & restart);
    assign gen_advance = done_go & ~restart;

    // A restart in the same cycle as a trigger must already fetch from line 0.
    assign start_base = idle_clear ? (base_addr & WORD_MASK) : line_base;

    vga_gfx_line_addr_gen #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_addr (base_addr),
        .stride    (stride),
        .num_lines (num_lines),
        .clear     (gen_clear),
        .advance   (gen_advance),
        .line      (line),
        .line_base (line_base)
    );

    // NOTE: all state and outputs use non-blocking assignments so every branch sees the
    // pre-edge values, exactly like the flops being described.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            word        <= '0;
            gap_cnt     <= '0;
            irq_q       <= 1'b0;
            enable_q    <= 1'b0;
            fs_pending  <= 1'b0;
            overrun     <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            gfx_address <= '0;
            gfx_data    <= '0;
            gfx_write_n <= GFX_IDLE;
            gfx_read_n  <= GFX_IDLE;
        end else begin
            irq_q    <= gfx_irq;
            enable_q <= enable;

            if (overrun_clr) begin
                overrun <= 1'b0;
            end else if (trigger && state != IDLE) begin
                overrun <= 1'b1;
            end

            // A restart requested mid-refill is held until the line counter is free.
            if (gen_clear) begin
                fs_pending <= 1'b0;
            end else if (frame_start && state != IDLE) begin
                fs_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    gfx_write_n <= GFX_IDLE;
                    gfx_read_n  <= GFX_IDLE;
                    if (trigger && enable && enable_q) begin
                        gfx_read_n  <= GFX_RD8;
                        gfx_address <= GFX_REG_IRQ;
                        word        <= '0;
                        mem_req     <= 1'b1;
                        mem_addr    <= start_base;
                        state       <= FETCH;
                    end
                end

                FETCH: begin
                    gfx_read_n <= GFX_IDLE;
                    // The memory handshake is never dropped; a disable takes effect at ack.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (enable) begin
                            gfx_write_n <= GFX_WR32;
                            gfx_address <= {word, 2'b00};
                            gfx_data    <= mem_rdata;
                            state       <= WRITE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                WRITE: begin
                    gfx_write_n <= GFX_IDLE;
                    gap_cnt     <= GAP_LOAD;
                    state       <= enable ? GAP : IDLE;
                end

                GAP: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end else if (word == LAST_WORD) begin
                        state <= DONE;
                    end else begin
                        word     <= word_next;
                        mem_req  <= 1'b1;
                        mem_addr <= line_base + {{(ADDR_W-6){1'b0}}, word_next, 2'b00};
                        state    <= FETCH;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_gfx_line_dma.sv
// Scoreboard bench for vga_gfx_line_dma: stimulus pushes expected reads/fetches/writes,
// a memory responder and bus monitor pop and compare them as the DUT presents them.
module tb_vga_gfx_line_dma;

    localparam int ADDR_W = 24;
    localparam int LINE_W = 10;
    localparam int WR_GAP = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] stride = '0;
    logic [LINE_W-1:0] num_lines = '0;
    logic              frame_start = 1'b0;
    logic              gfx_irq = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic [5:0]        gfx_address;
    logic [31:0]       gfx_data;
    logic [1:0]        gfx_write_n;
    logic [1:0]        gfx_read_n;
    logic              busy;
    logic [LINE_W-1:0] line;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_delay = 2;

    logic [ADDR_W-1:0] exp_fetch[$];
    logic [37:0]       exp_wr[$];
    int                exp_rd = 0;
    bit                follow_pending = 1'b0;
    int                last_wr_cyc = 0;
    logic [ADDR_W-1:0] resp_addr;
    bit                resp_held;
    logic [37:0]       wr_entry;

    vga_gfx_line_dma #(
        .ADDR_W (ADDR_W),
        .WORDS  (16),
        .WR_GAP (WR_GAP),
        .LINE_W (LINE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .base_addr   (base_addr),
        .stride      (stride),
        .num_lines   (num_lines),
        .frame_start (frame_start),
        .gfx_irq     (gfx_irq),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .gfx_address (gfx_address),
        .gfx_data    (gfx_data),
        .gfx_write_n (gfx_write_n),
        .gfx_read_n  (gfx_read_n),
        .busy        (busy),
        .line        (line),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'hA5C3_0000 ^ {8'h00, a};
    endfunction

    // Expected traffic for one refill of line l (base 0x1000, stride 0x40).
    task automatic push_line(input int l, input int n_fetch, input int n_write);
        logic [ADDR_W-1:0] a;
        exp_rd++;
        for (int w = 0; w < n_fetch; w++) begin
            a = 24'h001000 + ADDR_W'(l) * 24'h000040 + ADDR_W'(w) * 24'd4;
            exp_fetch.push_back(a);
            if (w < n_write) exp_wr.push_back({6'(w * 4), mem_word(a)});
        end
    endtask

    task automatic fire();
        @(negedge clk);
        gfx_irq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_after_irq", busy, 1'b1);
        gfx_irq = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now({name, "_timeout"});
    endtask

    task automatic refill(input int l, input int exp_line_after);
        push_line(l, 16, 16);
        fire();
        wait_idle("refill");
        check("line_after_refill", line, exp_line_after);
    endtask

    // Memory responder: checks each request address and that it is held until ack.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                resp_addr = mem_addr;
                resp_held = 1'b1;
                if (follow_pending) begin
                    check("write_to_fetch_spacing", cyc - last_wr_cyc, WR_GAP);
                    follow_pending = 1'b0;
                end
                if (exp_fetch.size() == 0) fail_now("unexpected_fetch");
                else check("fetch_addr", resp_addr, exp_fetch.pop_front());
                repeat (ack_delay) begin
                    @(negedge clk);
                    if (mem_req !== 1'b1 || mem_addr !== resp_addr) resp_held = 1'b0;
                end
                check("fetch_held_until_ack", resp_held, 1'b1);
                mem_ack   = 1'b1;
                mem_rdata = mem_word(resp_addr);
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    // Peripheral bus monitor.
    always @(negedge clk) begin
        if (gfx_write_n === 2'b10) begin
            if (exp_wr.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                wr_entry = exp_wr.pop_front();
                check("write_addr", gfx_address, wr_entry[37:32]);
                check("write_data", gfx_data, wr_entry[31:0]);
            end
            last_wr_cyc    = cyc;
            follow_pending = (gfx_address != 6'h3C);
        end
        if (gfx_read_n === 2'b00) begin
            if (exp_rd == 0) begin
                fail_now("unexpected_read");
            end else begin
                exp_rd--;
                check("ack_read_addr", gfx_address, 6'h01);
            end
        end
    end

    initial begin
        int n;
        base_addr = 24'h001000;
        stride    = 24'h000040;
        num_lines = 10'd4;
        enable    = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 24'h0);
        check("rst_write_n", gfx_write_n, 2'b11);
        check("rst_read_n", gfx_read_n, 2'b11);
        check("rst_gfx_addr", gfx_address, 6'h00);
        check("rst_gfx_data", gfx_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_line", line, 10'd0);
        check("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame of four lines, then wrap back to base.
        refill(0, 1);
        refill(1, 2);
        refill(2, 3);
        refill(3, 0);
        refill(0, 1);

        // Second edge mid-refill sets overrun without starting another refill.
        push_line(1, 16, 16);
        fire();
        repeat (20) @(negedge clk);
        gfx_irq = 1'b1;
        @(negedge clk);
        gfx_irq = 1'b0;
        @(negedge clk);
        check("overrun_set", overrun, 1'b1);
        wait_idle("overrun_refill");
        check("line_after_overrun", line, 10'd2);
        check("overrun_sticky", overrun, 1'b1);

        // Clear wins over a same-cycle set.
        push_line(2, 16, 16);
        fire();
        repeat (20) @(negedge clk);
        gfx_irq     = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        gfx_irq     = 1'b0;
        overrun_clr = 1'b0;
        @(negedge clk);
        check("overrun_clr_priority", overrun, 1'b0);
        wait_idle("clr_refill");
        check("line_after_clr", line, 10'd3);

        // frame_start while idle acts immediately.
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("line_fs_idle", line, 10'd0);
        refill(0, 1);
        refill(1, 2);

        // frame_start mid-refill: line 2 completes, then restart at line 0.
        push_line(2, 16, 16);
        fire();
        repeat (20) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_idle("fs_refill");
        check("line_after_fs_busy", line, 10'd0);
        refill(0, 1);

        // Disable while a fetch is outstanding with a slow ack.
        ack_delay = 5;
        push_line(1, 1, 0);
        fire();
        enable = 1'b0;
        wait_idle("abort_refill");
        check("abort_busy", busy, 1'b0);
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_line", line, 10'd1);
        repeat (3) @(negedge clk);
        ack_delay = 2;
        enable    = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset during GAP.
        push_line(1, 1, 1);
        fire();
        n = 0;
        while (gfx_write_n !== 2'b10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("wait_first_write_timeout");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_write_n", gfx_write_n, 2'b11);
        check("async_rst_read_n", gfx_read_n, 2'b11);
        check("async_rst_mem_req", mem_req, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("line_after_rst", line, 10'd0);
        check("overrun_after_rst", overrun, 1'b0);
        repeat (20) @(negedge clk);

        check("fetch_queue_drained", exp_fetch.size(), 0);
        check("write_queue_drained", exp_wr.size(), 0);
        check("read_queue_drained", exp_rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
